// File: rtl/serv_ifetch_align_pkg.sv
// Shared definitions for the halfword-aware instruction fetch stage:
// FSM state encoding and the compressed-instruction opcode test.
package serv_ifetch_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH0  = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_FETCH1  = 3'd3,
    ST_ACK     = 3'd4
  } state_e;

  // Low opcode bits of a full-length (32-bit) instruction
  localparam logic [1:0] OPC_FULL = 2'b11;

  function automatic logic is_comp(input logic [1:0] lsb);
    return lsb != OPC_FULL;
  endfunction

endpackage

// File: rtl/serv_ifetch_buf.sv
// One-word line buffer: tag/data/valid storage, hit compare and flush.
// A flush coincident with a write still stores the data but leaves it invalid.
module serv_ifetch_buf
  import serv_ifetch_align_pkg::*;
#(
  parameter bit BUF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_wr,
  input  logic [29:0] i_wr_tag,
  input  logic [31:0] i_wr_dat,
  input  logic [29:0] i_lk_tag,
  output logic        o_hit,
  output logic [31:0] o_dat
);

  logic [29:0] tag_q, tag_d;
  logic [31:0] dat_q, dat_d;
  logic        vld_q, vld_d;

  always_comb begin
    tag_d = tag_q;
    dat_d = dat_q;
    vld_d = vld_q;
    if (i_wr) begin
      tag_d = i_wr_tag;
      dat_d = i_wr_dat;
      vld_d = 1'b1;
    end
    if (i_flush) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      tag_q <= 30'd0;
      dat_q <= 32'd0;
      vld_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign o_hit = BUF_EN && vld_q && (tag_q == i_lk_tag);
  assign o_dat = dat_q;

endmodule

// File: rtl/serv_ifetch_align.sv
// Instruction fetch with halfword alignment: returns one compressed or 32-bit
// instruction per request, fetching a second word for straddling instructions.
module serv_ifetch_align
  import serv_ifetch_align_pkg::*;
#(
  parameter bit BUF_EN = 1'b1,
  parameter bit WITH_C = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [31:0] i_adr,
  input  logic        i_flush,
  output logic        o_ack,
  output logic [31:0] o_rdt,
  output logic        o_iscomp,
  output logic [31:0] o_mem_adr,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack
);

  state_e      state_q, state_d;
  logic [31:1] adr_q, adr_d;
  logic [15:0] lo_q, lo_d;
  logic        ack_q, ack_d;
  logic [31:0] rdt_q, rdt_d;
  logic        iscomp_q, iscomp_d;
  logic        cyc_q, cyc_d;
  logic [31:0] mem_adr_q, mem_adr_d;

  logic        buf_wr_s;
  logic        buf_hit_s;
  logic [31:0] buf_dat_s;
  logic        unused_s;

  assign unused_s = i_adr[0];

  serv_ifetch_buf #(.BUF_EN(BUF_EN)) u_buf (
    .clk      (clk),
    .i_rst    (i_rst),
    .i_flush  (i_flush),
    .i_wr     (buf_wr_s),
    .i_wr_tag (mem_adr_q[31:2]),
    .i_wr_dat (i_mem_rdt),
    .i_lk_tag (i_adr[31:2]),
    .o_hit    (buf_hit_s),
    .o_dat    (buf_dat_s)
  );

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    lo_d      = lo_q;
    ack_d     = 1'b0;
    rdt_d     = rdt_q;
    iscomp_d  = iscomp_q;
    cyc_d     = cyc_q;
    mem_adr_d = mem_adr_q;
    buf_wr_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          adr_d = i_adr[31:1];
          if (buf_hit_s) begin
            state_d = ST_RESOLVE;
          end else begin
            cyc_d     = 1'b1;
            mem_adr_d = {i_adr[31:2], 2'b00};
            state_d   = ST_FETCH0;
          end
        end
      end
      ST_FETCH0: begin
        if (i_mem_ack) begin
          buf_wr_s = 1'b1;
          cyc_d    = 1'b0;
          state_d  = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        // Without C support the PC is word aligned, so bit 1 is ignored
        if (!(WITH_C && adr_q[1])) begin
          ack_d   = 1'b1;
          state_d = ST_ACK;
          if (WITH_C && is_comp(buf_dat_s[1:0])) begin
            rdt_d    = {16'h0000, buf_dat_s[15:0]};
            iscomp_d = 1'b1;
          end else begin
            rdt_d    = buf_dat_s;
            iscomp_d = 1'b0;
          end
        end else if (is_comp(buf_dat_s[17:16])) begin
          ack_d    = 1'b1;
          rdt_d    = {16'h0000, buf_dat_s[31:16]};
          iscomp_d = 1'b1;
          state_d  = ST_ACK;
        end else begin
          // The next word can never already be buffered: its tag differs
          lo_d      = buf_dat_s[31:16];
          cyc_d     = 1'b1;
          mem_adr_d = {adr_q[31:2] + 30'd1, 2'b00};
          state_d   = ST_FETCH1;
        end
      end
      ST_FETCH1: begin
        if (i_mem_ack) begin
          buf_wr_s = 1'b1;
          cyc_d    = 1'b0;
          ack_d    = 1'b1;
          rdt_d    = {i_mem_rdt[15:0], lo_q};
          iscomp_d = 1'b0;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      adr_q     <= 31'd0;
      lo_q      <= 16'd0;
      ack_q     <= 1'b0;
      rdt_q     <= 32'd0;
      iscomp_q  <= 1'b0;
      cyc_q     <= 1'b0;
      mem_adr_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      lo_q      <= lo_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
      iscomp_q  <= iscomp_d;
      cyc_q     <= cyc_d;
      mem_adr_q <= mem_adr_d;
    end
  end

  assign o_ack     = ack_q;
  assign o_rdt     = rdt_q;
  assign o_iscomp  = iscomp_q;
  assign o_mem_adr = mem_adr_q;
  assign o_mem_cyc = cyc_q;

endmodule

// File: tb/tb_serv_ifetch_align.sv
// Directed bench: instance 0 is the default build, instance 1 has BUF_EN=0, WITH_C=0.
module tb_serv_ifetch_align;
  import serv_ifetch_align_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_s     [2];
  logic [31:0] adr_s     [2];
  logic        ack_s     [2];
  logic [31:0] rdt_s     [2];
  logic        comp_s    [2];
  logic [31:0] madr_s    [2];
  logic        cyc_s     [2];
  int          fetch_cnt [2];
  logic [31:0] last_adr  [2];

  logic flush_tb     = 1'b0;
  logic flush_on_ack = 1'b0;
  logic stall        = 1'b0;
  int   mem_wait     = 0;

  int ncmp = 0;
  int nerr = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hBBBB_00A0;
      32'h0000_0100: return 32'h00A0_0093;
      32'h0000_0200: return 32'h4501_4501;
      32'h0000_0300: return 32'h0093_1111;
      32'h0000_0304: return 32'hAAAA_00A0;
      32'h0000_0400: return 32'h0000_4501;
      32'h0000_0500: return 32'h1234_56F3;
      32'hFFFF_FFFC: return 32'h0093_1234;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit P = (g == 0);
    logic        flush_s;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdt = 32'h0;
    logic [31:0] acc_adr = 32'h0;
    int          cnt     = 0;
    int          nacc    = 0;

    assign flush_s      = flush_tb | (flush_on_ack & mem_ack);
    assign fetch_cnt[g] = nacc;
    assign last_adr[g]  = acc_adr;

    serv_ifetch_align #(.BUF_EN(P), .WITH_C(P)) u_dut (
      .clk       (clk),
      .i_rst     (rst),
      .i_req     (req_s[g]),
      .i_adr     (adr_s[g]),
      .i_flush   (flush_s),
      .o_ack     (ack_s[g]),
      .o_rdt     (rdt_s[g]),
      .o_iscomp  (comp_s[g]),
      .o_mem_adr (madr_s[g]),
      .o_mem_cyc (cyc_s[g]),
      .i_mem_rdt (mem_rdt),
      .i_mem_ack (mem_ack)
    );

    // Memory: single-cycle ack after mem_wait idle cycles while cyc is high
    always @(posedge clk) begin
      if (mem_ack) begin
        mem_ack <= 1'b0;
      end else if (cyc_s[g] && !stall) begin
        if (cnt >= mem_wait) begin
          mem_ack <= 1'b1;
          mem_rdt <= mem_word(madr_s[g]);
          acc_adr <= madr_s[g];
          nacc    <= nacc + 1;
          cnt     <= 0;
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end

    always @(posedge clk) begin
      if (!rst && req_s[g]) begin
        assert (u_dut.state_q == ST_IDLE)
          else $error("FAIL protocol: i_req outside IDLE on instance %0d", g);
      end
    end
  end

  typedef struct {
    int          d;
    logic [31:0] adr;
    int          wt;
    logic [31:0] rdt;
    logic        comp;
    int          nf;
    int          lat;
    logic [31:0] last;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic do_fetch(input int d, input logic [31:0] a, output logic [31:0] rdt,
                          output logic comp, output int nf, output int lat, output bit to);
    int n0;
    @(negedge clk);
    n0       = fetch_cnt[d];
    req_s[d] = 1'b1;
    adr_s[d] = a;
    @(negedge clk);
    req_s[d] = 1'b0;
    lat = 1;
    to  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (ack_s[d]) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
    end
    rdt  = rdt_s[d];
    comp = comp_s[d];
    nf   = fetch_cnt[d] - n0;
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] e_rdt,
                     input logic e_comp, input int e_nf, input int e_lat, input string nm);
    logic [31:0] rdt;
    logic        comp;
    int          nf, lat;
    bit          to;
    do_fetch(d, a, rdt, comp, nf, lat, to);
    chk({nm, "_timeout"}, 32'(to), 32'd0);
    chk({nm, "_rdt"}, rdt, e_rdt);
    chk({nm, "_iscomp"}, 32'(comp), 32'(e_comp));
    chk({nm, "_fetches"}, 32'(nf), 32'(e_nf));
    if (e_lat >= 0) chk({nm, "_latency"}, 32'(lat), 32'(e_lat));
    @(negedge clk);
    chk({nm, "_ackpulse"}, 32'(ack_s[d]), 32'd0);
    chk({nm, "_rdthold"}, rdt_s[d], e_rdt);
  endtask

  initial begin
    int acks;
    int n0;
    req_s[0] = 1'b0; req_s[1] = 1'b0;
    adr_s[0] = 32'h0; adr_s[1] = 32'h0;

    vecs[0]  = '{0, 32'h0000_0100, 1, 32'h00A0_0093, 1'b0, 1, -1, 32'h0000_0100};
    vecs[1]  = '{0, 32'h0000_0200, 0, 32'h0000_4501, 1'b1, 1, -1, 32'h0000_0200};
    vecs[2]  = '{0, 32'h0000_0202, 0, 32'h0000_4501, 1'b1, 0,  2, 32'h0};
    vecs[3]  = '{0, 32'h0000_0302, 3, 32'h00A0_0093, 1'b0, 2, -1, 32'h0000_0304};
    vecs[4]  = '{0, 32'h0000_0304, 0, 32'h0000_00A0, 1'b1, 0,  2, 32'h0};
    vecs[5]  = '{0, 32'h0000_0306, 0, 32'h0000_AAAA, 1'b1, 0,  2, 32'h0};
    vecs[6]  = '{0, 32'hFFFF_FFFE, 1, 32'h00A0_0093, 1'b0, 2, -1, 32'h0000_0000};
    vecs[7]  = '{0, 32'h0000_0000, 0, 32'h0000_00A0, 1'b1, 0,  2, 32'h0};
    vecs[8]  = '{0, 32'h0000_0400, 0, 32'h0000_4501, 1'b1, 1, -1, 32'h0000_0400};
    vecs[9]  = '{0, 32'h0000_0500, 2, 32'h1234_56F3, 1'b0, 1, -1, 32'h0000_0500};
    vecs[10] = '{0, 32'h0000_0502, 0, 32'h0000_1234, 1'b1, 0,  2, 32'h0};
    vecs[11] = '{1, 32'h0000_0400, 0, 32'h0000_4501, 1'b0, 1, -1, 32'h0000_0400};
    vecs[12] = '{1, 32'h0000_0400, 1, 32'h0000_4501, 1'b0, 1, -1, 32'h0000_0400};
    vecs[13] = '{1, 32'h0000_0100, 0, 32'h00A0_0093, 1'b0, 1, -1, 32'h0000_0100};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ack", 32'(ack_s[0]), 32'd0);
    chk("reset_cyc", 32'(cyc_s[0]), 32'd0);
    chk("reset_rdt", rdt_s[0], 32'd0);
    chk("reset_iscomp", 32'(comp_s[0]), 32'd0);
    chk("reset_memadr", madr_s[0], 32'd0);

    for (int i = 0; i < 14; i++) begin
      mem_wait = vecs[i].wt;
      run(vecs[i].d, vecs[i].adr, vecs[i].rdt, vecs[i].comp, vecs[i].nf, vecs[i].lat,
          $sformatf("vec%0d", i));
      if (vecs[i].nf > 0) chk($sformatf("vec%0d_lastadr", i), last_adr[vecs[i].d], vecs[i].last);
    end

    // Flush between two hits forces a refetch of the same word
    mem_wait = 1;
    run(0, 32'h0000_0200, 32'h0000_4501, 1'b1, 1, -1, "fl_miss");
    run(0, 32'h0000_0202, 32'h0000_4501, 1'b1, 0, 2, "fl_hit");
    @(negedge clk);
    flush_tb = 1'b1;
    @(negedge clk);
    flush_tb = 1'b0;
    run(0, 32'h0000_0202, 32'h0000_4501, 1'b1, 1, -1, "fl_refetch");
    chk("fl_refetch_adr", last_adr[0], 32'h0000_0200);

    // Flush coincident with the memory ack: data delivered, buffer left invalid
    flush_on_ack = 1'b1;
    run(0, 32'h0000_0100, 32'h00A0_0093, 1'b0, 1, -1, "flack");
    flush_on_ack = 1'b0;
    run(0, 32'h0000_0102, 32'h0000_00A0, 1'b1, 1, -1, "flack_next");

    // Reset during a stalled fetch: cyc drops, no ack, buffer invalidated
    stall = 1'b1;
    @(negedge clk);
    req_s[0] = 1'b1;
    adr_s[0] = 32'h0000_0600;
    @(negedge clk);
    req_s[0] = 1'b0;
    chk("rst_mid_cyc_before", 32'(cyc_s[0]), 32'd1);
    chk("rst_mid_adr_before", madr_s[0], 32'h0000_0600);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_cyc_after", 32'(cyc_s[0]), 32'd0);
    chk("rst_mid_ack_after", 32'(ack_s[0]), 32'd0);
    stall = 1'b0;
    n0   = fetch_cnt[0];
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack_s[0] || cyc_s[0]) acks++;
    end
    chk("rst_mid_quiet", 32'(acks), 32'd0);
    chk("rst_mid_nofetch", 32'(fetch_cnt[0] - n0), 32'd0);
    run(0, 32'h0000_0102, 32'h0000_00A0, 1'b1, 1, -1, "rst_after");
    run(0, 32'h0000_0600, 32'h0000_0013, 1'b0, 1, -1, "rst_after2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/serv_ifetch_align.md
Name: serv_ifetch_align

Overview:
- Instruction-fetch stage directly downstream of the bit-serial PC unit. It takes the 32-bit instruction address that unit produces and fetches 32-bit aligned words over the ibus.
- Returns one complete instruction to the decoder: either a 16-bit compressed instruction (zero-extended) or a 32-bit instruction, with the compressed flag that drives the PC's +2/+4 selection.
- Handles halfword-aligned PCs, including 32-bit instructions that straddle a word boundary.
- A one-word line buffer avoids refetching the current word.

Parameters:
- BUF_EN, 1: 1 enables line-buffer reuse; 0 forces a memory fetch for every request.
- WITH_C, 1: 1 enables compressed/halfword support; 0 treats every instruction as 32-bit, and the PC must then be word aligned.

Ports:
- clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  1  single-cycle fetch request; sampled only in IDLE
- i_adr  in  32  instruction address (PC); bit 0 is always 0; sampled with i_req
- i_flush  in  1  invalidate the line buffer (fence.i / boot-mode change)
- o_ack  out  1  one-cycle pulse: o_rdt and o_iscomp are valid
- o_rdt  out  32  instruction; for compressed, {16'h0, half}
- o_iscomp  out  1  1 when the instruction is 16-bit
- o_mem_adr  out  32  word address to memory; bits [1:0] are always 0
- o_mem_cyc  out  1  memory request, held until i_mem_ack
- i_mem_rdt  in  32  memory read data
- i_mem_ack  in  1  memory acknowledge; single cycle; data valid with it

Behaviour:
- Reset: o_ack=0, o_mem_cyc=0, o_rdt=0, o_iscomp=0, o_mem_adr=0, buffer valid=0, state=IDLE. Reset mid-fetch aborts the fetch, drops o_mem_cyc the next cycle and produces no ack.
- Registers:
  - adr_r: latched i_adr.
  - buf_tag[31:2] and buf_dat[31:0]: the line buffer.
  - buf_vld.
  - lo_r[15:0]: upper half of the first word, kept for a straddling instruction.
- Definitions:
  - Compressed test: half[1:0] != 2'b11 (only when WITH_C=1).
  - hit(a) = BUF_EN & buf_vld & (buf_tag == a[31:2]).
- States:
  - IDLE: on i_req, latch i_adr.
    - If hit(i_adr): go to RESOLVE.
    - Otherwise: drive o_mem_adr={i_adr[31:2],2'b00}, assert o_mem_cyc, go to FETCH0.
  - FETCH0: on i_mem_ack, write buf_dat, buf_tag and buf_vld=1, deassert o_mem_cyc, go to RESOLVE.
  - RESOLVE (word w = buf_dat):
    - adr_r[1]=0: if w[1:0] != 2'b11, ack with {16'h0,w[15:0]} and iscomp=1; otherwise ack with w and iscomp=0.
    - adr_r[1]=1 and w[17:16] != 2'b11: ack with {16'h0,w[31:16]} and iscomp=1.
    - adr_r[1]=1, otherwise: lo_r=w[31:16]. If hit(adr_r+4) go to RESOLVE2 (not reachable with a one-word buffer, tag mismatch); otherwise drive o_mem_adr=adr_r[31:2]+1 word, assert o_mem_cyc, go to FETCH1.
  - FETCH1: on i_mem_ack, update the buffer with the new word, then ack with {i_mem_rdt[15:0], lo_r} and iscomp=0 in the next cycle. Return to IDLE.
- o_ack is registered. It is high for exactly 1 cycle, in the cycle after RESOLVE or FETCH1 completes. o_rdt and o_iscomp hold their values until the next ack.
- Latency from i_req to o_ack:
  - Buffer hit: 2 cycles.
  - Miss: 2 + memory wait cycles.
  - Straddling instruction: adds a second memory access.
- Address arithmetic: the 30-bit word increment wraps 0x3FFFFFFF→0 silently.
- i_req outside IDLE is ignored. It is a protocol error; the bench asserts it never happens.
- i_flush clears buf_vld the next cycle in any state. A flush coincident with i_mem_ack: the data is still delivered, but buf_vld ends 0 (flush wins).
- o_mem_cyc never drops without i_mem_ack, except on reset.

Decomposition:
- Shared package/header:
  - state encoding (IDLE, FETCH0, RESOLVE, FETCH1, ACK);
  - the localparam for the compressed opcode mask 2'b11.
- One natural sub-module: serv_ifetch_buf, holding the tag, data, valid, hit compare and flush logic. The FSM stays in the top module.

Test Plan:
- Aligned 32-bit: i_adr=0x100 with memory word 0x00A00093 (addi), ack after 1 wait cycle -> one o_mem_cyc to 0x100, then o_ack with o_rdt=0x00A00093 and o_iscomp=0.
- Compressed pair reuse: word at 0x200 = 0x45014501. Request 0x200 -> rdt=0x00004501, iscomp=1. Request 0x202 -> same result with no o_mem_cyc (hit); latency 2 cycles.
- Straddle: 0x300=0x00931111, 0x304=0xAAAA00A0; request 0x302 -> two fetches (0x300, then 0x304), rdt=0x00A00093, iscomp=0. The buffer then holds tag 0x304.
- Flush: after a hit on 0x200, pulse i_flush, then request 0x202 -> a new fetch to 0x200 occurs. Flush coincident with i_mem_ack -> the ack still happens, and the next request misses.
- Reset mid-fetch: assert i_rst during FETCH0 while memory is stalled -> next cycle o_mem_cyc=0, no o_ack, buffer invalid; a new request after reset fetches normally.
- BUF_EN=0 and WITH_C=0 builds: every request issues o_mem_cyc; with WITH_C=0, word 0x00004501 returns iscomp=0 and rdt=0x00004501.
